// File: rtl/spi_sensor_arbiter.sv
// rtl/spi_sensor_arbiter.sv - round-robin arbiter sharing one SPI master among NCH sensor clients
// Optional START/BUSY watchdog enabled by defining SPI_TIMEOUT_EN.
module spi_sensor_arbiter #(
  parameter int NCH         = 4,
  parameter int CH_W        = 2,
  parameter int CBITS       = 16,
  parameter int STARTUP_CYC = 36000,
  parameter int GAP_CYC     = 12000,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic            spi_not_busy,
  input  logic [31:0]     spi_rx_data,
  output logic            spi_ena,
  output logic [CH_W-1:0] spi_sel,
  output logic [31:0]     rd_data,
  output logic [CH_W-1:0] rd_ch,
  output logic            done,
  output logic            busy,
  output logic            timeout
);

`ifdef SPI_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [CBITS-1:0] CNT_ONE  = CBITS'(1);
  localparam logic [CBITS-1:0] PWR_LAST = CBITS'(STARTUP_CYC - 1);
  localparam logic [CBITS-1:0] GAP_LAST = CBITS'(GAP_CYC - 1);
  localparam logic [CBITS-1:0] TO_LAST  = CBITS'(TIMEOUT_CYC - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);
  localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);

  typedef enum logic [2:0] {
    WAIT_PWR = 3'd0,
    IDLE     = 3'd1,
    START    = 3'd2,
    BUSY     = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CBITS-1:0]  cnt, cnt_nxt;
  logic [CH_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CH_W-1:0]   grant, idx;
  logic              grant_vld;
  logic              to_hit;

  logic              spi_ena_nxt, done_nxt, busy_nxt, timeout_nxt;
  logic [CH_W-1:0]   spi_sel_nxt, rd_ch_nxt;
  logic [31:0]       rd_data_nxt;

  // Watchdog compare is constant-false when the feature is compiled out.
  assign to_hit = TO_EN && (cnt == TO_LAST);

  // First requesting client at or after rr_ptr, wrapping at NCH.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = CH_W'((int'(rr_ptr) + i) % NCH);
      if (!grant_vld && req[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT_PWR;
      cnt     <= '0;
      rr_ptr  <= '0;
      spi_ena <= 1'b0;
      spi_sel <= '0;
      rd_data <= '0;
      rd_ch   <= '0;
      done    <= 1'b0;
      busy    <= 1'b1;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rr_ptr  <= rr_ptr_nxt;
      spi_ena <= spi_ena_nxt;
      spi_sel <= spi_sel_nxt;
      rd_data <= rd_data_nxt;
      rd_ch   <= rd_ch_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rr_ptr_nxt = rr_ptr;
    case (state)
      WAIT_PWR: begin
        if (cnt == PWR_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE: begin
        cnt_nxt = '0;
        if (grant_vld) begin
          state_nxt  = START;
          rr_ptr_nxt = (grant == CH_LAST) ? '0 : grant + CH_ONE;
        end
      end
      START: begin
        if (!spi_not_busy) begin
          state_nxt = BUSY;
          cnt_nxt   = '0;
        end else if (to_hit) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else if (TO_EN) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      BUSY: begin
        if (spi_not_busy || to_hit) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else if (TO_EN) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    spi_ena_nxt = 1'b0;
    spi_sel_nxt = spi_sel;
    rd_data_nxt = rd_data;
    rd_ch_nxt   = rd_ch;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          spi_ena_nxt = 1'b1;
          spi_sel_nxt = grant;
        end
      end
      START: begin
        if (spi_not_busy && to_hit) begin
          timeout_nxt = 1'b1;
          rd_ch_nxt   = spi_sel;
        end else if (spi_not_busy) begin
          spi_ena_nxt = 1'b1;
        end
      end
      BUSY: begin
        if (spi_not_busy) begin
          rd_data_nxt = spi_rx_data;
          rd_ch_nxt   = spi_sel;
          done_nxt    = 1'b1;
        end else if (to_hit) begin
          timeout_nxt = 1'b1;
          rd_ch_nxt   = spi_sel;
        end
      end
      default: spi_ena_nxt = 1'b0;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule
